// File: rtl/window_h_generator_fp16_if.sv
// Pixel-stream bundle for the horizontal window generator: upstream pixel
// handshake plus the registered window output that feeds the 1xN convolution.
interface window_h_generator_fp16_if #(
  parameter int FP_WIDTH_REG = 16,
  parameter int WINDOW_WIDTH = 9
);
  logic [FP_WIDTH_REG-1:0]                   data_i;
  logic [15:0]                               col_i;
  logic [15:0]                               row_i;
  logic                                      valid_i;
  logic                                      ready_o;
  logic [WINDOW_WIDTH-1:0][FP_WIDTH_REG-1:0] window_o;
  logic [15:0]                               col_o;
  logic [15:0]                               row_o;
  logic                                      valid_o;

  // master: pixel source / window consumer; slave: the window generator
  modport master (
    output data_i, col_i, row_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o
  );

  modport slave (
    input  data_i, col_i, row_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/window_h_generator_fp16.sv
// Row-stream to centred 1 x WINDOW_WIDTH window converter with border padding.
// The right border is produced by a HALF-cycle flush during which upstream is stalled.
module window_h_generator_fp16 #(
  parameter int EXP_WIDTH    = 5,
  parameter int FRAC_WIDTH   = 10,
  parameter int WINDOW_WIDTH = 9,
  parameter int IMAGE_WIDTH  = 640,
  parameter int BORDER_MODE  = 0,
  parameter int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  window_h_generator_fp16_if.slave        bus
);

  localparam int          HALF       = (WINDOW_WIDTH - 1) / 2;
  localparam logic [15:0] HALF_C     = 16'(HALF);
  localparam logic [15:0] LAST_COL   = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] FLUSH_BASE = 16'(IMAGE_WIDTH - HALF);

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    FLUSH
  } state_t;

  state_t                  state_reg;
  logic                    ready_reg;
  logic                    valid_reg;
  logic [15:0]             col_reg;
  logic [15:0]             row_reg;
  logic [15:0]             row_latch_reg;
  logic [15:0]             flush_cnt_reg;
  logic [FP_WIDTH_REG-1:0] sr_reg [WINDOW_WIDTH];

  logic                    xfer;
  logic                    col_zero;
  logic                    load_row;
  logic                    shift_px;
  logic                    shift_pad;
  logic [FP_WIDTH_REG-1:0] left_pad;
  logic [FP_WIDTH_REG-1:0] right_pad;

  always_comb begin
    xfer      = bus.valid_i & ready_reg;
    col_zero  = (bus.col_i == 16'd0);
    load_row  = xfer & col_zero & (state_reg != FLUSH);
    shift_px  = xfer & ~col_zero & (state_reg == ROW);
    shift_pad = (state_reg == FLUSH);
    left_pad  = (BORDER_MODE == 1) ? bus.data_i : '0;
    // Replicate mode keeps re-inserting the last pixel, which stays at the tail during flush.
    right_pad = (BORDER_MODE == 1) ? sr_reg[WINDOW_WIDTH-1] : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < WINDOW_WIDTH; gi++) begin : g_sr
      if (gi == WINDOW_WIDTH - 1) begin : g_tail
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            sr_reg[gi] <= '0;
          end else if (load_row || shift_px) begin
            sr_reg[gi] <= bus.data_i;
          end else if (shift_pad) begin
            sr_reg[gi] <= right_pad;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            sr_reg[gi] <= '0;
          end else if (load_row) begin
            sr_reg[gi] <= left_pad;
          end else if (shift_px || shift_pad) begin
            sr_reg[gi] <= sr_reg[gi+1];
          end
        end
      end
      assign bus.window_o[gi] = sr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b1;
      valid_reg     <= 1'b0;
      col_reg       <= 16'd0;
      row_reg       <= 16'd0;
      row_latch_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      valid_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (load_row) begin
            row_latch_reg <= bus.row_i;
            state_reg     <= ROW;
          end
        end
        ROW: begin
          // A col-0 pixel mid-row restarts the row; the partial row is never flushed.
          if (load_row) begin
            row_latch_reg <= bus.row_i;
          end else if (shift_px) begin
            if (bus.col_i >= HALF_C) begin
              valid_reg <= 1'b1;
              col_reg   <= bus.col_i - HALF_C;
              row_reg   <= row_latch_reg;
            end
            if (bus.col_i == LAST_COL) begin
              state_reg     <= FLUSH;
              ready_reg     <= 1'b0;
              flush_cnt_reg <= 16'd0;
            end
          end
        end
        FLUSH: begin
          valid_reg     <= 1'b1;
          col_reg       <= FLUSH_BASE + flush_cnt_reg;
          row_reg       <= row_latch_reg;
          flush_cnt_reg <= flush_cnt_reg + 16'd1;
          if (flush_cnt_reg == HALF_C - 16'd1) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_reg;
  assign bus.valid_o = valid_reg;
  assign bus.col_o   = col_reg;
  assign bus.row_o   = row_reg;

endmodule

// File: tb/tb_window_h_generator_fp16.sv
// Scoreboard bench: two generators (zero pad and replicate) share one pixel stream;
// a reference model builds expected windows from the row's pixels, a monitor checks outputs.
module tb_window_h_generator_fp16;

  localparam int W    = 9;
  localparam int IW   = 12;
  localparam int HALF = (W - 1) / 2;
  localparam int FPW  = 16;

  typedef logic [W-1:0][FPW-1:0] win_t;
  typedef struct {
    win_t        win;
    logic [15:0] col;
    logic [15:0] row;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [FPW-1:0]  data;
  logic [15:0]     col;
  logic [15:0]     row;
  logic            valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int flush_at = -1000;

  exp_t        q_z[$];
  exp_t        q_r[$];
  logic [15:0] model_px[IW];
  logic [15:0] stim_px[IW];
  bit          in_row = 1'b0;
  logic [15:0] cur_row = 16'd0;

  window_h_generator_fp16_if #(.FP_WIDTH_REG(FPW), .WINDOW_WIDTH(W)) bus_z ();
  window_h_generator_fp16_if #(.FP_WIDTH_REG(FPW), .WINDOW_WIDTH(W)) bus_r ();

  assign bus_z.data_i  = data;
  assign bus_z.col_i   = col;
  assign bus_z.row_i   = row;
  assign bus_z.valid_i = valid;
  assign bus_r.data_i  = data;
  assign bus_r.col_i   = col;
  assign bus_r.row_i   = row;
  assign bus_r.valid_i = valid;

  window_h_generator_fp16 #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(W), .IMAGE_WIDTH(IW), .BORDER_MODE(0)
  ) dut_z (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_z)
  );

  window_h_generator_fp16 #(
    .EXP_WIDTH(5), .FRAC_WIDTH(10), .WINDOW_WIDTH(W), .IMAGE_WIDTH(IW), .BORDER_MODE(1)
  ) dut_r (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] int_to_fp16(input int n);
    int e;
    int mant;
    if (n == 0) return 16'h0000;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    mant = ((n << 10) >> e) & 32'h3ff;
    return {1'b0, 5'(e + 15), 10'(mant)};
  endfunction

  // Window centred on 'centre' taken straight from the row's pixel list.
  function automatic win_t make_win(input int centre, input bit rep);
    win_t w;
    int   idx;
    for (int k = 0; k < W; k++) begin
      idx = centre - HALF + k;
      if (idx < 0)        w[k] = rep ? model_px[0] : 16'h0000;
      else if (idx >= IW) w[k] = rep ? model_px[IW-1] : 16'h0000;
      else                w[k] = model_px[idx];
    end
    return w;
  endfunction

  task automatic push_exp(input int centre);
    exp_t e;
    e.col = 16'(centre);
    e.row = cur_row;
    e.win = make_win(centre, 1'b0);
    q_z.push_back(e);
    e.win = make_win(centre, 1'b1);
    q_r.push_back(e);
  endtask

  task automatic model_accept(input logic [15:0] c, input logic [15:0] r, input logic [15:0] d);
    if (c == 16'd0) begin
      in_row      = 1'b1;
      cur_row     = r;
      model_px[0] = d;
    end else if (in_row) begin
      model_px[c] = d;
      if (int'(c) >= HALF) push_exp(int'(c) - HALF);
      if (int'(c) == IW - 1) begin
        for (int n = IW - HALF; n < IW; n++) push_exp(n);
        in_row   = 1'b0;
        flush_at = cyc;
      end
    end
  endtask

  task automatic xfer(input logic [15:0] c, input logic [15:0] r, input logic [15:0] d);
    bit acc;
    bit exp_rdy;
    int waited;
    acc    = 1'b0;
    waited = 0;
    data   = d;
    col    = c;
    row    = r;
    valid  = 1'b1;
    while (!acc && waited < 50) begin
      exp_rdy = !((cyc > flush_at) && (cyc <= flush_at + HALF));
      chk("ready_zero", bus_z.ready_o, exp_rdy);
      chk("ready_rep", bus_r.ready_o, exp_rdy);
      if (bus_z.ready_o) begin
        model_accept(c, r, d);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    valid = 1'b0;
    if (!acc) chk("xfer_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_row(input logic [15:0] r, input int ncols, input int gap_max);
    for (int c = 0; c < ncols; c++) begin
      if (gap_max > 0 && c > 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, gap_max));
      xfer(16'(c), r, stim_px[c]);
    end
  endtask

  task automatic mon_one(input bit which, input logic v, input win_t w,
                         input logic [15:0] c, input logic [15:0] r);
    exp_t  e;
    string nm;
    bit    empty;
    nm = which ? "win_rep" : "win_zero";
    if (v) begin
      n_tests++;
      empty = which ? (q_r.size() == 0) : (q_z.size() == 0);
      if (empty) begin
        n_fail++;
        $display("FAIL %s_unexpected: got col=%0d row=%0d win=%h want no output", nm, c, r, w);
      end else begin
        e = which ? q_r.pop_front() : q_z.pop_front();
        if (w !== e.win || c !== e.col || r !== e.row) begin
          n_fail++;
          $display("FAIL %s: got col=%0d row=%0d win=%h want col=%0d row=%0d win=%h",
                   nm, c, r, w, e.col, e.row, e.win);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_one(1'b0, bus_z.valid_o, bus_z.window_o, bus_z.col_o, bus_z.row_o);
      mon_one(1'b1, bus_r.valid_o, bus_r.window_o, bus_r.col_o, bus_r.row_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    data  = '0;
    col   = '0;
    row   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus_z.ready_o, 1);
    chk("rst_valid", bus_z.valid_o, 0);
    chk("rst_col", bus_z.col_o, 0);
    chk("rst_row", bus_z.row_o, 0);
    chk("rst_win_zero", (bus_z.window_o == '0), 1);
    chk("rst_win_rep", (bus_r.window_o == '0), 1);
    rst_n = 1'b1;
    idle(2);

    // Column-index pixels, zero pad, no gaps
    for (int c = 0; c < IW; c++) stim_px[c] = int_to_fp16(c);
    send_row(16'd0, IW, 0);
    // 10+col pixels, col 0 presented while the previous row flushes
    for (int c = 0; c < IW; c++) stim_px[c] = int_to_fp16(10 + c);
    send_row(16'd1, IW, 0);

    // Random data including NaN/inf/negative patterns, with input gaps
    for (int c = 0; c < IW; c++) stim_px[c] = 16'($urandom_range(0, 65535));
    send_row(16'd2, IW, 3);
    for (int r = 3; r <= 4; r++) begin
      for (int c = 0; c < IW; c++) stim_px[c] = 16'($urandom_range(0, 65535));
      send_row(16'(r), IW, 0);
    end

    // Non-zero column while idle is dropped
    idle(8);
    xfer(16'd5, 16'd9, 16'h1234);
    @(negedge clk);
    chk("drop_valid_zero", bus_z.valid_o, 0);
    chk("drop_valid_rep", bus_r.valid_o, 0);
    #1;

    // Short row abandoned at col 6, new row starts without flush
    for (int c = 0; c < IW; c++) stim_px[c] = 16'($urandom_range(0, 65535));
    send_row(16'd5, 7, 0);
    for (int c = 0; c < IW; c++) stim_px[c] = 16'($urandom_range(0, 65535));
    send_row(16'd6, IW, 2);

    // Asynchronous reset right after col 7 is accepted
    idle(8);
    for (int c = 0; c < IW; c++) stim_px[c] = 16'($urandom_range(0, 65535));
    send_row(16'd7, 8, 0);
    chk("pre_rst_valid", bus_z.valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid_zero", bus_z.valid_o, 0);
    chk("rst_mid_valid_rep", bus_r.valid_o, 0);
    chk("rst_mid_ready_zero", bus_z.ready_o, 1);
    chk("rst_mid_ready_rep", bus_r.ready_o, 1);
    q_z.delete();
    q_r.delete();
    in_row   = 1'b0;
    flush_at = -1000;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < IW; c++) stim_px[c] = int_to_fp16(10 + c);
    send_row(16'd8, IW, 0);

    // Random rows with random gaps before each row and between pixels
    for (int r = 10; r < 26; r++) begin
      for (int c = 0; c < IW; c++) stim_px[c] = 16'($urandom_range(0, 65535));
      idle($urandom_range(0, 6));
      send_row(16'(r), IW, 3);
    end

    for (int i = 0; i < 30 && (q_z.size() != 0 || q_r.size() != 0); i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain_zero", q_z.size(), 0);
    chk("drain_rep", q_r.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
